// File: rtl/lower_part_or_rca32_aor_enc64_pkg.sv
// Shared constants for the key-locked lower-part-OR adder (LOA_KEY_LOCK_EN enables the key gates).
package lower_part_or_rca32_aor_enc64_pkg;

  localparam int unsigned OPND_W  = 32;
  localparam int unsigned RES_W   = 33;
  localparam int unsigned KEY_W   = 64;

  localparam int unsigned LOWER_W_MIN = 1;
  localparam int unsigned LOWER_W_MAX = 31;

  // A 1 marks an AND key gate, a 0 marks an OR key gate.
  localparam logic [KEY_W-1:0] K_CORRECT = 64'h67EC_D36F_4ADB_ABF5;

endpackage

// File: rtl/lower_part_or_rca32_aor_enc64_loa_core.sv
// Combinational lower-part-OR adder core: OR'd low field, ripple-carry high field.
module loa_core
  import lower_part_or_rca32_aor_enc64_pkg::*;
#(
  parameter int unsigned LOWER_W = 8
) (
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [RES_W-1:0]  s
);

  localparam int unsigned UPPER_W = OPND_W - LOWER_W;

  if (LOWER_W < LOWER_W_MIN || LOWER_W > LOWER_W_MAX) begin : g_bad_lower_w
    $error("loa_core: LOWER_W out of range");
  end

  logic             cin;
  logic [UPPER_W:0] carry;
  logic [UPPER_W-1:0] upper_sum;

  // Carry into the exact part comes only from the top bit of the OR'd field.
  assign cin = a[LOWER_W-1] & b[LOWER_W-1];

  always_comb begin
    carry     = '0;
    upper_sum = '0;
    carry[0]  = cin;
    for (int i = 0; i < int'(UPPER_W); i++) begin
      upper_sum[i] = a[LOWER_W+i] ^ b[LOWER_W+i] ^ carry[i];
      carry[i+1]   = (a[LOWER_W+i] & b[LOWER_W+i]) |
                     (carry[i] & (a[LOWER_W+i] ^ b[LOWER_W+i]));
    end
  end

  assign s = {carry[UPPER_W], upper_sum, a[LOWER_W-1:0] | b[LOWER_W-1:0]};

endmodule

// File: rtl/lower_part_or_rca32_aor_enc64.sv
// Key-locked 32-bit LOA adder with registered 33-bit result.
// Define LOA_KEY_LOCK_EN to insert the AND/OR key-gate layer; otherwise keyinput is ignored.
module lower_part_or_rca32_aor_enc64
  import lower_part_or_rca32_aor_enc64_pkg::*;
#(
  parameter int unsigned LOWER_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [OPND_W-1:0] add1_i,
  input  logic [OPND_W-1:0] add2_i,
  input  logic [KEY_W-1:0]  keyinput,
  output logic              valid_o,
  output logic [RES_W-1:0]  result_o
);

  logic [OPND_W-1:0] a_gated;
  logic [OPND_W-1:0] b_gated;
  logic [RES_W-1:0]  sum;

`ifdef LOA_KEY_LOCK_EN
  logic [KEY_W-1:0] opnd_cat;
  logic [KEY_W-1:0] gated_cat;

  assign opnd_cat = {add2_i, add1_i};

  // Correct key bit is the identity element of each gate; a wrong bit forces a constant.
  always_comb begin
    gated_cat = '0;
    for (int j = 0; j < int'(KEY_W); j++) begin
      if (K_CORRECT[j]) gated_cat[j] = opnd_cat[j] & keyinput[j];
      else              gated_cat[j] = opnd_cat[j] | keyinput[j];
    end
  end

  assign a_gated = gated_cat[OPND_W-1:0];
  assign b_gated = gated_cat[KEY_W-1:OPND_W];
`else
  logic unused_key;

  assign unused_key = ^keyinput;
  assign a_gated    = add1_i;
  assign b_gated    = add2_i;
`endif

  loa_core #(
    .LOWER_W (LOWER_W)
  ) u_loa_core (
    .a (a_gated),
    .b (b_gated),
    .s (sum)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) result_o <= sum;
    end
  end

endmodule

// File: tb/tb_lower_part_or_rca32_aor_enc64.sv
// Directed bench for the key-locked LOA adder; expectations follow LOA_KEY_LOCK_EN.
module tb_lower_part_or_rca32_aor_enc64;

  localparam logic [63:0] K_OK      = 64'h67EC_D36F_4ADB_ABF5;
  localparam logic [63:0] K_BAD_AND = 64'h67EC_D36F_4ADB_AB75;
  localparam logic [63:0] K_BAD_OR  = 64'hE7EC_D36F_4ADB_ABF5;

`ifdef LOA_KEY_LOCK_EN
  localparam logic [32:0] EXP_BAD_AND = 33'h0_0000_0080;
  localparam logic [32:0] EXP_BAD_OR  = 33'h0_8000_0000;
`else
  localparam logic [32:0] EXP_BAD_AND = 33'h0_0000_0180;
  localparam logic [32:0] EXP_BAD_OR  = 33'h0_0000_0000;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic [31:0] add1_i;
  logic [31:0] add2_i;
  logic [63:0] keyinput;
  logic        valid_o;
  logic [32:0] result_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  lower_part_or_rca32_aor_enc64 #(.LOWER_W(8)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .add1_i   (add1_i),
    .add2_i   (add2_i),
    .keyinput (keyinput),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  task automatic check_res(input string tag, input logic [32:0] exp);
    tests++;
    assert (result_o === exp) else begin
      fails++;
      $error("FAIL %s: result_o=%h expected %h", tag, result_o, exp);
    end
  endtask

  task automatic check_vld(input string tag, input logic exp);
    tests++;
    assert (valid_o === exp) else begin
      fails++;
      $error("FAIL %s: valid_o=%b expected %b", tag, valid_o, exp);
    end
  endtask

  // Present one operand set on the falling edge, then sample just after the capture edge.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [63:0] k);
    @(negedge clk_i);
    valid_i  = 1'b1;
    add1_i   = a;
    add2_i   = b;
    keyinput = k;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni   = 1'b0;
    valid_i  = 1'b1;
    add1_i   = 32'hFFFF_FFFF;
    add2_i   = 32'hFFFF_FFFF;
    keyinput = K_OK;
    #1;
    check_res("reset_imm_res", 33'h0);
    check_vld("reset_imm_vld", 1'b0);
    @(posedge clk_i); #1;
    check_res("reset_edge_res", 33'h0);
    check_vld("reset_edge_vld", 1'b0);

    @(negedge clk_i);
    valid_i = 1'b0;
    rst_ni  = 1'b1;

    apply(32'h0000_000F, 32'h0000_00F0, K_OK);
    check_res("lower_only", 33'h0_0000_00FF);
    check_vld("first_valid", 1'b1);

    apply(32'h0000_0080, 32'h0000_0080, K_OK);
    check_res("loa_carry", 33'h0_0000_0180);

    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, K_OK);
    check_res("full_max", 33'h1_FFFF_FFFF);

    apply(32'hFFFF_FFFF, 32'h0000_0001, K_OK);
    check_res("full_plus1", 33'h0_FFFF_FFFF);

    apply(32'h0000_0080, 32'h0000_0080, K_BAD_AND);
    check_res("bad_and_key", EXP_BAD_AND);

    apply(32'h0000_0080, 32'h0000_0080, K_OK);
    check_res("key_restored", 33'h0_0000_0180);
    check_vld("key_restored_vld", 1'b1);

    apply(32'h0000_0000, 32'h0000_0000, K_BAD_OR);
    check_res("bad_or_key", EXP_BAD_OR);

    apply(32'h1234_5600, 32'h1111_1100, K_OK);
    check_res("mid_values", 33'h0_2345_6700);

    // Hold for three cycles with garbage on the operand bus.
    @(negedge clk_i);
    valid_i = 1'b0;
    add1_i  = 32'hDEAD_BEEF;
    add2_i  = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check_res($sformatf("hold_res_%0d", i), 33'h0_2345_6700);
      check_vld($sformatf("hold_vld_%0d", i), 1'b0);
    end

    #2;
    rst_ni = 1'b0;
    #1;
    check_res("mid_hold_reset_res", 33'h0);
    check_vld("mid_hold_reset_vld", 1'b0);

    @(negedge clk_i);
    rst_ni = 1'b1;
    apply(32'h0000_0003, 32'h0000_0004, K_OK);
    check_res("after_reset", 33'h0_0000_0007);
    check_vld("after_reset_vld", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
